// File: rtl/fm_audio_pkg.sv
// Shared widths, FSM state types and output saturation for the FM audio
// de-emphasis/decimation path.
package fm_audio_pkg;

  localparam int IN_W       = 24;
  localparam int OUT_W      = 16;
  localparam int ROUND_BIAS = 128;
  localparam int RND_SH     = $clog2(ROUND_BIAS) + 1;
  localparam int SAT_HI     = (1 <<< (OUT_W - 1)) - 1;
  localparam int SAT_LO     = -SAT_HI - 1;

  typedef enum logic [1:0] {IDLE, FILT, ACC, ACKH} in_state_e;
  typedef enum logic [1:0] {O_IDLE, O_REQ, O_REL} out_state_e;

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [IN_W:0] r);
    if (r > (IN_W+1)'(SAT_HI)) begin
      return OUT_W'(SAT_HI);
    end else if (r < (IN_W+1)'(SAT_LO)) begin
      return OUT_W'(SAT_LO);
    end else begin
      return OUT_W'(r);
    end
  endfunction

endpackage

// File: rtl/deemph_iir.sv
// First-order de-emphasis IIR: y <= y + ((x - y) >>> ALPHA_SHIFT), updated on en_i.
module deemph_iir
  import fm_audio_pkg::*;
#(
  parameter int unsigned ALPHA_SHIFT = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   en_i,
  input  logic signed [IN_W-1:0] x_i,
  output logic signed [IN_W-1:0] y_o
);

  logic signed [IN_W-1:0] y_q, y_d;
  logic signed [IN_W:0]   diff, step;

  // The new y always lies between old y and x, so truncating back to IN_W is exact.
  always_comb begin
    diff = (IN_W+1)'(x_i) - (IN_W+1)'(y_q);
    step = diff >>> ALPHA_SHIFT;
    y_d  = IN_W'((IN_W+1)'(y_q) + step);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q <= '0;
    end else if (en_i) begin
      y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/fm_audio_deemph_decim.sv
// De-emphasis, boxcar decimation by 2^DECIM_LOG2, round and saturate to 16-bit
// audio; 4-phase RDY/ACK handshakes on both sides.
module fm_audio_deemph_decim
  import fm_audio_pkg::*;
#(
  parameter int unsigned DECIM_LOG2  = 3,
  parameter int unsigned ALPHA_SHIFT = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic signed [IN_W-1:0]  IN_DATA,
  input  logic                    IN_RDY,
  output logic                    IN_ACK,
  output logic signed [OUT_W-1:0] OUT_DATA,
  output logic                    OUT_RDY,
  input  logic                    OUT_ACK
);

  localparam int unsigned AW = IN_W + DECIM_LOG2;
  localparam int unsigned CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << DECIM_LOG2) - 1);

  in_state_e               in_state_q;
  out_state_e              out_state_q;
  logic signed [IN_W-1:0]  x_q, y;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]           cnt_q;
  logic                    in_ack_q, out_rdy_q;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic signed [IN_W-1:0]  avg;
  logic signed [IN_W:0]    rsum, rnd;
  logic                    wrap, out_free, load;

  deemph_iir #(.ALPHA_SHIFT(ALPHA_SHIFT)) u_iir (
    .CLK  (CLK),
    .RST  (RST),
    .en_i (in_state_q == FILT),
    .x_i  (x_q),
    .y_o  (y)
  );

  always_comb begin
    acc_d      = acc_q + AW'(y);
    avg        = IN_W'(acc_d >>> DECIM_LOG2);
    rsum       = (IN_W+1)'(avg) + (IN_W+1)'(ROUND_BIAS);
    rnd        = rsum >>> RND_SH;
    out_data_d = sat_out(rnd);
  end

  // Free is judged on registered state only, so a completion and a load never share an edge.
  assign wrap     = (cnt_q == CNT_LAST);
  assign out_free = (out_state_q == O_IDLE) && !OUT_ACK;
  assign load     = (in_state_q == ACC) && wrap && out_free;

  always_ff @(posedge CLK) begin
    if (RST) begin
      in_state_q <= IDLE;
      x_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      in_ack_q   <= 1'b0;
    end else begin
      case (in_state_q)
        IDLE: begin
          if (IN_RDY) begin
            x_q        <= IN_DATA;
            in_state_q <= FILT;
          end
        end
        FILT: in_state_q <= ACC;
        ACC: begin
          if (!wrap) begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_q + 1'b1;
            in_state_q <= ACKH;
          end else if (out_free) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            in_state_q <= ACKH;
          end
        end
        ACKH: begin
          in_ack_q <= 1'b1;
          if (in_ack_q && !IN_RDY) begin
            in_ack_q   <= 1'b0;
            in_state_q <= IDLE;
          end
        end
        default: in_state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_state_q <= O_IDLE;
      out_rdy_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (out_state_q)
        O_IDLE: begin
          if (load) begin
            out_data_q  <= out_data_d;
            out_rdy_q   <= 1'b1;
            out_state_q <= O_REQ;
          end
        end
        O_REQ: begin
          if (OUT_ACK) begin
            out_rdy_q   <= 1'b0;
            out_state_q <= O_REL;
          end
        end
        O_REL: begin
          if (!OUT_ACK) out_state_q <= O_IDLE;
        end
        default: out_state_q <= O_IDLE;
      endcase
    end
  end

  assign IN_ACK   = in_ack_q;
  assign OUT_RDY  = out_rdy_q;
  assign OUT_DATA = out_data_q;

endmodule

// File: tb/tb_fm_audio_deemph_decim.sv
// Scoreboard bench: three DUT configurations, directed vectors, sink model checks outputs.
module tb_fm_audio_deemph_decim;

  logic clk = 1'b0;
  logic rst;
  logic signed [23:0] in_data [3];
  logic               in_rdy  [3];
  logic               in_ack  [3];
  logic signed [15:0] out_data[3];
  logic               out_rdy [3];
  logic               out_ack [3];

  typedef struct {
    int idx;
    int val;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int ack_delay[3];
  int done_cnt[3];
  int sst[3];
  int wcnt[3];

  always #5 clk = ~clk;

  fm_audio_deemph_decim #(.DECIM_LOG2(2), .ALPHA_SHIFT(2)) dut0 (
    .CLK(clk), .RST(rst), .IN_DATA(in_data[0]), .IN_RDY(in_rdy[0]), .IN_ACK(in_ack[0]),
    .OUT_DATA(out_data[0]), .OUT_RDY(out_rdy[0]), .OUT_ACK(out_ack[0]));
  fm_audio_deemph_decim #(.DECIM_LOG2(2), .ALPHA_SHIFT(0)) dut1 (
    .CLK(clk), .RST(rst), .IN_DATA(in_data[1]), .IN_RDY(in_rdy[1]), .IN_ACK(in_ack[1]),
    .OUT_DATA(out_data[1]), .OUT_RDY(out_rdy[1]), .OUT_ACK(out_ack[1]));
  fm_audio_deemph_decim #(.DECIM_LOG2(0), .ALPHA_SHIFT(0)) dut2 (
    .CLK(clk), .RST(rst), .IN_DATA(in_data[2]), .IN_RDY(in_rdy[2]), .IN_ACK(in_ack[2]),
    .OUT_DATA(out_data[2]), .OUT_RDY(out_rdy[2]), .OUT_ACK(out_ack[2]));

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push_exp(input int i, input int v);
    exp_t e;
    e.idx = i;
    e.val = v;
    sb.push_back(e);
  endtask

  // Full 4-phase input transfer; dc returns the sink completion count seen when ACK rose.
  task automatic send(input int i, input int d, input int extra, input bit toggle, output int dc);
    int n;
    @(negedge clk);
    in_data[i] = 24'(d);
    in_rdy[i]  = 1'b1;
    n = 0;
    while (in_ack[i] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    dc = done_cnt[i];
    chk($sformatf("ack_rise%0d", i), int'(in_ack[i]), 1);
    for (int k = 0; k < extra; k++) begin
      @(negedge clk);
      if (toggle) in_data[i] = 24'($urandom);
      chk($sformatf("ack_hold%0d", i), int'(in_ack[i]), 1);
    end
    @(negedge clk);
    in_rdy[i] = 1'b0;
    if (toggle) in_data[i] = 24'($urandom);
    n = 0;
    while (in_ack[i] !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ack_fall%0d", i), int'(in_ack[i]), 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || sst[0] != 0 || sst[1] != 0 || sst[2] != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        case (sst[i])
          0: if (out_rdy[i] === 1'b1) begin
               wcnt[i] = ack_delay[i];
               sst[i]  = 1;
             end
          1: if (out_rdy[i] !== 1'b1) begin
               sst[i] = 0;
             end else if (wcnt[i] == 0) begin
               if (sb.size() == 0) begin
                 total++;
                 bad++;
                 $display("FAIL extra_out%0d: got %0d expected no output", i, out_data[i]);
               end else begin
                 e = sb.pop_front();
                 if (e.idx != i) begin
                   total++;
                   bad++;
                   $display("FAIL out_port: got dut%0d expected dut%0d", i, e.idx);
                 end else begin
                   chk($sformatf("out_data%0d", i), int'(out_data[i]), e.val);
                 end
               end
               out_ack[i] = 1'b1;
               sst[i]     = 2;
             end else begin
               wcnt[i]--;
             end
          default: if (out_rdy[i] !== 1'b1) begin
               out_ack[i] = 1'b0;
               done_cnt[i]++;
               sst[i] = 0;
             end
        endcase
      end
    end
  endtask

  task automatic stimulus();
    int n, dc, base;
    // Reset again while dut2 holds a pending output in O_REQ.
    ack_delay[2] = 1000;
    send(2, 25600, 0, 0, dc);
    n = 0;
    while (out_rdy[2] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("oreq_rdy", int'(out_rdy[2]), 1);
    chk("oreq_data", int'(out_data[2]), 100);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_ack", int'(in_ack[2]), 0);
    chk("rst_mid_rdy", int'(out_rdy[2]), 0);
    chk("rst_mid_data", int'(out_data[2]), 0);
    @(negedge clk);
    rst = 1'b0;
    ack_delay[2] = 3;
    repeat (10) @(negedge clk);

    // y = 16384, 28672, 37888, 44800 -> avg 31936 -> 125
    push_exp(0, 125);
    for (int k = 0; k < 4; k++) send(0, 65536, 0, 0, dc);
    drain();

    push_exp(1, 32767);
    for (int k = 0; k < 4; k++) send(1, 24'h7FFFFF, 0, 0, dc);
    push_exp(1, -1);
    for (int k = 0; k < 4; k++) send(1, -256, 0, 0, dc);
    push_exp(1, 10);
    for (int k = 1; k <= 4; k++) send(1, 1000 * k, 0, 0, dc);
    drain();

    // Minimum input latency: sampled at edge k, ACK high only after edge k+3.
    push_exp(2, 100);
    @(negedge clk);
    in_data[2] = 24'(25600);
    in_rdy[2]  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("lat_k2", int'(in_ack[2]), 0);
    @(posedge clk);
    #1;
    chk("lat_k3", int'(in_ack[2]), 1);
    @(negedge clk);
    in_rdy[2] = 1'b0;
    n = 0;
    while (in_ack[2] !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("lat_fall", int'(in_ack[2]), 0);
    drain();

    // Slow sink: second sample must be held off until the first transfer completes.
    ack_delay[2] = 50;
    base = done_cnt[2];
    push_exp(2, 100);
    push_exp(2, 200);
    send(2, 25600, 0, 0, dc);
    chk("stall_first", dc, base);
    send(2, 51200, 0, 0, dc);
    chk("stall_order", dc, base + 1);
    drain();
    ack_delay[2] = 3;

    // Data wiggles after ACK and RDY held long: one sample, latched value.
    push_exp(2, -100);
    send(2, -25600, 10, 1, dc);
    repeat (20) @(negedge clk);
    drain();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data[i]   = '0;
      in_rdy[i]    = 1'b0;
      out_ack[i]   = 1'b0;
      ack_delay[i] = 3;
      done_cnt[i]  = 0;
      sst[i]       = 0;
      wcnt[i]      = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ack%0d", i), int'(in_ack[i]), 0);
      chk($sformatf("rst_rdy%0d", i), int'(out_rdy[i]), 0);
      chk($sformatf("rst_data%0d", i), int'(out_data[i]), 0);
    end
    rst = 1'b0;
    fork
      monitor();
      stimulus();
      begin
        #500000;
        total++;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fm_audio_deemph_decim.md
Name: fm_audio_deemph_decim

Overview:
- Downstream consumer of the FM demodulator output: accepts 24-bit signed discriminator samples over the 4-phase RDY/ACK handshake.
- Applies a first-order de-emphasis IIR, then boxcar-decimates by 2^DECIM_LOG2.
- Rounds and saturates to 16-bit audio, presented to the audio sink over the same 4-phase handshake.

Parameters:
- DECIM_LOG2, 3: decimation factor = 2^DECIM_LOG2; legal range 0..6; 0 means pass-through, every filtered sample is emitted.
- ALPHA_SHIFT, 4: de-emphasis coefficient alpha = 2^-ALPHA_SHIFT; legal range 0..15; 0 means the filter is bypassed (y = x).

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset; synchronous and active-high.
- IN_DATA  in  24  signed demodulator sample; valid while IN_RDY is high.
- IN_RDY  in  1  upstream request.
- IN_ACK  out  1  acknowledge to upstream.
- OUT_DATA  out  16  signed audio sample; held stable while OUT_RDY is high.
- OUT_RDY  out  1  request to the audio sink.
- OUT_ACK  in  1  acknowledge from the audio sink.

Behaviour:
- Reset (RST high at an edge): IN_ACK=0, OUT_RDY=0, OUT_DATA=0, filter state y=0, accumulator=0, sample count=0, both FSMs return to IDLE.
- Reset mid-handshake: any pending output is dropped and a partial decimation sum is discarded.

Input handshake (4-phase):
- IN_ACK rises only after the sample has been fully absorbed.
- IN_ACK stays high until IN_RDY is sampled low, then falls on the next edge.
- A new sample is accepted only when IN_RDY=1 and IN_ACK=0.

Input FSM:
- IDLE: on IN_RDY=1, latch IN_DATA into x -> FILT.
- FILT: y <= y + ((x - y) >>> ALPHA_SHIFT). Difference is 25-bit signed, arithmetic shift. Result always lies between the old y and x, so no saturation is needed -> ACC.
- ACC: acc <= acc + y; cnt <= cnt + 1. acc width is 24+DECIM_LOG2, signed.
  - If cnt wraps (the 2^DECIM_LOG2-th sample) and the output register is busy (OUT_RDY=1 or OUT_ACK=1): stall in ACC with no state update.
  - If cnt wraps and the output register is free: load the output, clear acc and cnt -> ACKH.
  - Otherwise -> ACKH.
- ACKH: IN_ACK=1; on IN_RDY=0 -> IDLE with IN_ACK=0.
- Minimum latency: IN_RDY sampled high at edge k gives IN_ACK=1 after edge k+3.

Output arithmetic:
- avg = (acc + y) >>> DECIM_LOG2, a 24-bit signed value.
- r = (avg + 128) >>> 8, computed at 25 bits (round half up).
- Saturate r to [-32768, 32767]; the result becomes OUT_DATA.

Output FSM:
- O_IDLE: when the output is loaded, OUT_RDY=1 -> O_REQ.
- O_REQ: on OUT_ACK=1, OUT_RDY=0 -> O_REL.
- O_REL: on OUT_ACK=0 -> O_IDLE.
- The output register is free only in O_IDLE with OUT_ACK=0.

Boundary conditions:
- Simultaneous input wrap and output completion: completion is observed first, so a load in the same cycle is allowed only if the register is already free at that edge (no combinational bypass).
- Stall: upstream simply sees IN_ACK delayed; no sample is lost.
- IN_DATA changing while IN_ACK is high is ignored.

Decomposition:
- Package fm_audio_pkg holds: IN_W=24, OUT_W=16, ROUND_BIAS=128, the input-FSM state encodings (IDLE, FILT, ACC, ACKH), the output-FSM state encodings (O_IDLE, O_REQ, O_REL), and the saturation function.
- Sub-module deemph_iir (x in, enable, y state/out, synchronous RST): isolates the filter datapath for reuse in the stereo path.

Test Plan:
- Reset, then reset again during O_REQ -> IN_ACK=0, OUT_RDY=0, OUT_DATA=0 one edge after RST; the pending sample never appears.
- DECIM_LOG2=2, ALPHA_SHIFT=2, four inputs of 65536 from reset -> y = 16384, 28672, 37888, 44800; avg=31936; OUT_DATA=125.
- DECIM_LOG2=2, ALPHA_SHIFT=0, four inputs of 0x7FFFFF -> OUT_DATA=32767 (saturated); four inputs of -256 -> OUT_DATA=-1 (0xFFFF).
- DECIM_LOG2=0, ALPHA_SHIFT=0, input 25600 -> OUT_DATA=100; IN_ACK rises exactly 3 edges after IN_RDY is sampled high.
- DECIM_LOG2=0, sink holds OUT_ACK low for 50 cycles -> the second input's IN_ACK is withheld until after O_REL completes; its OUT_DATA value is correct and no sample is lost or duplicated.
- Upstream toggles IN_DATA while IN_ACK is high, and IN_RDY is held high for 10 extra cycles -> exactly one sample is consumed and the latched value is used.
